// File: rtl/tdc_boot_sequencer.sv
// Power-up enable and staggered per-channel soft-reset sequencer for a TDC array,
// driven by single-byte host commands. Define TDC_SEQ_AUTOBOOT_EN to self-start after rst.
module tdc_boot_sequencer #(
   parameter int NUM_CH         = 6,
   parameter int CNT_W          = 20,
   parameter int EN_LOW_CYCLES  = 16,
   parameter int BOOT_CYCLES    = 1000000,
   parameter int STAGGER_CYCLES = 3000,
   parameter int PULSE_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              new_rx_data,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              tdc_enable,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              go_home,
   output logic              pause,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] EN_LOW_LAST  = CNT_W'(EN_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOOT_LAST    = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      EN_LOW,
      BOOT_WAIT,
      RST_GAP,
      RST_PULSE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;

   logic cmd_d, cmd_r, cmd_x, cmd_h, cmd_s, cmd_p;
   logic start;

   assign cmd_d = new_rx_data && (rx_data == 8'h64);
   assign cmd_r = new_rx_data && (rx_data == 8'h72);
   assign cmd_x = new_rx_data && (rx_data == 8'h78);
   assign cmd_h = new_rx_data && (rx_data == 8'h68);
   assign cmd_s = new_rx_data && (rx_data == 8'h73);
   assign cmd_p = new_rx_data && (rx_data == 8'h70);

`ifdef TDC_SEQ_AUTOBOOT_EN
   logic boot_pending;

   always_ff @(posedge clk) begin
      if (rst) boot_pending <= 1'b1;
      else     boot_pending <= 1'b0;
   end

   assign start = cmd_d || boot_pending;
`else
   assign start = cmd_d;
`endif

   // Masked channels are skipped in zero time: the next slot is always the
   // lowest unmasked channel at or after the candidate index.
   logic             first_found, next_found;
   logic [IDX_W-1:0] first_idx, next_idx;

   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_found = 1'b1;
            first_idx   = IDX_W'(i);
         end
         if (ch_mask[i] && (i > int'(idx))) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(i);
         end
      end
   end

   logic [CNT_W-1:0] cnt_last;
   logic             at_end;

   always_comb begin
      cnt_last = '0;
      case (state)
         EN_LOW:    cnt_last = EN_LOW_LAST;
         BOOT_WAIT: cnt_last = BOOT_LAST;
         RST_GAP:   cnt_last = STAGGER_LAST;
         RST_PULSE: cnt_last = PULSE_LAST;
         default:   cnt_last = '0;
      endcase
   end

   assign at_end = (cnt == cnt_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         tdc_enable <= 1'b0;
         soft_reset <= '0;
         go_home    <= 1'b0;
         pause      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cmd_h) go_home <= 1'b1;
         if (cmd_s) pause   <= 1'b1;
         if (cmd_p) pause   <= 1'b0;

         // State-changing commands take priority over any terminal count.
         if (start) begin
            state      <= EN_LOW;
            cnt        <= '0;
            idx        <= '0;
            tdc_enable <= 1'b0;
            soft_reset <= '0;
            go_home    <= 1'b0;
            busy       <= 1'b1;
         end else if (cmd_x) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            tdc_enable <= 1'b0;
            soft_reset <= '0;
            busy       <= 1'b0;
         end else if (cmd_r && (state == IDLE) && tdc_enable) begin
            cnt <= '0;
            if (first_found) begin
               state <= RST_GAP;
               idx   <= first_idx;
               busy  <= 1'b1;
            end else begin
               done <= 1'b1;
            end
         end else begin
            case (state)
               EN_LOW: begin
                  if (at_end) begin
                     state      <= BOOT_WAIT;
                     cnt        <= '0;
                     tdc_enable <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               BOOT_WAIT: begin
                  if (at_end) begin
                     cnt <= '0;
                     if (first_found) begin
                        state <= RST_GAP;
                        idx   <= first_idx;
                     end else begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RST_GAP: begin
                  if (at_end) begin
                     state      <= RST_PULSE;
                     cnt        <= '0;
                     soft_reset <= NUM_CH'(1) << idx;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RST_PULSE: begin
                  if (at_end) begin
                     cnt        <= '0;
                     soft_reset <= '0;
                     if (next_found) begin
                        state <= RST_GAP;
                        idx   <= next_idx;
                     end else begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/tdc_boot_sequencer.md
# tdc_boot_sequencer

Parametrised power-up and soft-reset sequencer for an array of TDC front-ends, controlled by single-byte serial commands. It sits between the UART receiver and the per-channel TDC configuration blocks. It drives a shared TDC enable, then issues staggered per-channel soft-reset pulses, with channel count, delays and per-channel masking configurable. It also holds the go_home and pause flags and reports busy/done to the host-side logic.

## Interface
Parameters:
- NUM_CH, 6, number of TDC channels (1..16)
- CNT_W, 20, width of the shared delay counter
- EN_LOW_CYCLES, 16, cycles tdc_enable is held low before boot (≥1)
- BOOT_CYCLES, 1000000, cycles enable is high before the first soft reset (≥1)
- STAGGER_CYCLES, 3000, wait before each channel's pulse (≥1)
- PULSE_CYCLES, 1, soft_reset pulse width (≥1)
- Every delay parameter must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- rx_data  in  8  received command byte
- new_rx_data  in  1  one-cycle strobe qualifying rx_data
- ch_mask  in  NUM_CH  1 = channel takes part in soft-reset sequence; sampled per channel when that channel's slot begins
- tdc_enable  out  1  shared TDC enable
- soft_reset  out  NUM_CH  per-channel soft-reset pulse; at most one bit high
- go_home  out  1  go-home request flag
- pause  out  1  pause flag
- busy  out  1  high while the sequence runs
- done  out  1  one-cycle pulse when the sequence completes

## Operation
- All outputs are registered. Reset values: tdc_enable=0, soft_reset=0, go_home=0, pause=0, busy=0, done=0, state IDLE, counter 0, channel index 0.
- States:
  - IDLE: no activity.
  - EN_LOW: tdc_enable=0 for EN_LOW_CYCLES, then go to BOOT_WAIT.
  - BOOT_WAIT: tdc_enable=1 for BOOT_CYCLES, then go to RST_GAP with index 0.
  - RST_GAP: wait STAGGER_CYCLES, then go to RST_PULSE.
  - RST_PULSE: soft_reset[idx]=1 for PULSE_CYCLES, then advance idx. If idx was the last channel, go to IDLE and pulse done; otherwise return to RST_GAP.
- Channels with ch_mask[i]=0 are skipped at zero cycle cost. If all channels are masked, done fires on the cycle after BOOT_WAIT ends.
- busy=1 in every state except IDLE.
- Commands are acted on only when new_rx_data=1. Other byte values are ignored.
  - "d": restart from EN_LOW from any state. Clears go_home, clears soft_reset and counter.
  - "r": in IDLE with tdc_enable=1, go straight to RST_GAP with idx 0. Ignored if busy or tdc_enable=0.
  - "x": abort. State goes to IDLE; tdc_enable=0, soft_reset=0, busy=0, no done pulse.
  - "h": sets go_home; it stays set until "d" or rst.
  - "s": sets pause.
  - "p": clears pause.
- A command that lands on the same cycle as a state's terminal count overrides the normal transition.
- rst mid-sequence returns everything to reset values on the next edge.

## Timing
- A command accepted at edge E takes effect in the outputs after edge E (1-cycle latency).
- With "d" at E0:
  - tdc_enable rises at edge E0+EN_LOW_CYCLES.
  - The first soft_reset (channel 0, unmasked) rises at E0+EN_LOW_CYCLES+BOOT_CYCLES+STAGGER_CYCLES.
- Each subsequent unmasked channel's pulse rises PULSE_CYCLES+STAGGER_CYCLES after the previous one's rise.
- done rises, and busy falls, on the edge where the last pulse falls.
- The counter never wraps: it counts from 0 to N−1 and reloads to 0 on every state change.

## Configuration
- TDC_SEQ_AUTOBOOT_EN defined: on the first cycle after rst deasserts, the block behaves as if "d" were received, so enable and reset sequencing run without a host command.
- Not defined: the block stays in IDLE with tdc_enable=0 until "d" arrives.

## Test plan
All scenarios use NUM_CH=3, EN_LOW_CYCLES=2, BOOT_CYCLES=10, STAGGER_CYCLES=4, PULSE_CYCLES=1, ch_mask=3'b111, autoboot off.
- "d" at E0 -> tdc_enable rises at E2. soft_reset[0] is high for E16–E17, [1] for E21–E22, [2] for E26–E27. done is pulsed at E27 and busy is low from E27.
- ch_mask=3'b101, "d" at E0 -> soft_reset[0] rises at E16 and [2] at E21. soft_reset[1] is never high. done at E22.
- "x" at E18 during sequence -> after E18: state IDLE, tdc_enable=0, soft_reset=0, busy=0, done never pulses.
- "h", then "s", then "p", then "d" -> go_home=1 after "h", pause=1 after "s", pause=0 after "p", go_home=0 after "d".
- After completion, "r" at E0 -> tdc_enable stays 1 and soft_reset[0] rises at E4. Sending "r" while busy changes nothing.
- rst asserted at E14 mid-BOOT_WAIT -> all outputs return to reset values after E14; no pulse until a new "d".
